// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer that feeds camera pixels into the
// convolution datapath through a single-entry output register, tags edge
// pixels, then flushes IMG_W+1 zero pixels so the line buffers drain.
module conv_frame_ctrl #(
  parameter int W     = 30,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   kernel_sel,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] conv_data,
  output logic         conv_valid,
  input  logic         conv_ready,
  output logic [1:0]   conv_kernel,
  output logic         border,
  output logic         busy,
  output logic         done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = $clog2(IMG_W + 2);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(IMG_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [FW-1:0]  flush_q, flush_d;
  logic [W-1:0]   conv_data_q, conv_data_d;
  logic           conv_valid_q, conv_valid_d;
  logic           border_q, border_d;
  logic [1:0]     kernel_q, kernel_d;
  logic           slot_free;
  logic           accept;
  logic           edge_pix;

  // The output register can take a new pixel when empty or draining this cycle.
  always_comb begin
    slot_free = !conv_valid_q || conv_ready;
    in_ready  = (state_q == RUN) && slot_free;
    accept    = in_valid && in_ready;
    edge_pix  = (col_q == '0) || (col_q == COL_LAST) ||
                (row_q == '0) || (row_q == ROW_LAST);
  end

  // Next-state, counter and output-register logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    flush_d      = flush_q;
    conv_data_d  = conv_data_q;
    conv_valid_d = conv_valid_q;
    border_d     = border_q;
    kernel_d     = kernel_q;

    if (conv_valid_q && conv_ready) begin
      conv_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          kernel_d = kernel_sel;
          col_d    = '0;
          row_d    = '0;
        end
      end
      RUN: begin
        if (accept) begin
          conv_data_d  = in_data;
          conv_valid_d = 1'b1;
          border_d     = edge_pix;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = FLUSH;
              flush_d = FLUSH_INIT;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      FLUSH: begin
        if (flush_q != '0) begin
          if (slot_free) begin
            conv_data_d  = '0;
            conv_valid_d = 1'b1;
            border_d     = 1'b1;
            flush_d      = flush_q - FW'(1);
          end
        end else if (slot_free) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      flush_q      <= '0;
      conv_data_q  <= '0;
      conv_valid_q <= 1'b0;
      border_q     <= 1'b0;
      kernel_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      flush_q      <= flush_d;
      conv_data_q  <= conv_data_d;
      conv_valid_q <= conv_valid_d;
      border_q     <= border_d;
      kernel_q     <= kernel_d;
    end
  end

  // Status outputs decode directly from the registered state.
  always_comb begin
    conv_data   = conv_data_q;
    conv_valid  = conv_valid_q;
    border      = border_q;
    conv_kernel = kernel_q;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
  end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Testbench for conv_frame_ctrl: drives frames with directed and random
// handshakes; expected pixels are queued on accept and popped on transfer.
module tb_conv_frame_ctrl;

  localparam int W     = 30;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NFLUSH = IMG_W + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         brd;
    logic         last;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   kernel_sel;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] conv_data;
  logic         conv_valid;
  logic         conv_ready;
  logic [1:0]   conv_kernel;
  logic         border;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  exp_t         exp_q[$];
  int           acc_idx = 0;
  logic         exp_done = 1'b0;
  logic [1:0]   exp_kernel = 2'b00;
  logic         stall_hold = 1'b0;
  logic [W-1:0] held_data;
  logic         held_border;

  conv_frame_ctrl #(.W(W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .kernel_sel (kernel_sel),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .conv_data  (conv_data),
    .conv_valid (conv_valid),
    .conv_ready (conv_ready),
    .conv_kernel(conv_kernel),
    .border     (border),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Frame rule: a pixel is on the border when it sits on the first/last column or row.
  function automatic logic border_of(input int idx);
    int c, r;
    c = idx % IMG_W;
    r = idx / IMG_W;
    return (c == 0) || (c == IMG_W - 1) || (r == 0) || (r == IMG_H - 1);
  endfunction

  // Monitor and scoreboard: sample between edges, pop on transfer, push on accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_idx    = 0;
      exp_done   = 1'b0;
      stall_hold = 1'b0;
    end else begin
      if (done || exp_done) check_output("done_pulse", done, exp_done);
      exp_done = 1'b0;
      if (!busy) check_output("idle_in_ready", in_ready, 0);
      if (stall_hold) begin
        check_output("stall_valid", conv_valid, 1);
        check_output("stall_data", conv_data, held_data);
        check_output("stall_border", border, held_border);
      end
      if (conv_valid && !conv_ready) begin
        stall_hold  = 1'b1;
        held_data   = conv_data;
        held_border = border;
        check_output("stall_in_ready", in_ready, 0);
      end else begin
        stall_hold = 1'b0;
      end
      if (conv_valid && conv_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_transfer", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_output("conv_data", conv_data, e.data);
          check_output("border", border, e.brd);
          check_output("conv_kernel", conv_kernel, exp_kernel);
          if (e.last) exp_done = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{data: in_data, brd: border_of(acc_idx), last: 1'b0});
        acc_idx++;
        if (acc_idx == NPIX) begin
          for (int f = 0; f < NFLUSH; f++)
            exp_q.push_back('{data: '0, brd: 1'b1, last: (f == NFLUSH - 1)});
          acc_idx = 0;
        end
      end
    end
  end

  function automatic logic ready_for(input int rmode, input int cyc);
    case (rmode)
      0: return 1'b1;
      1: return ($urandom_range(0, 3) != 0);
      default: return !(cyc >= 6 && cyc <= 8);
    endcase
  endfunction

  // One frame: vmode 0=always valid, 1=toggling, 2=random; rmode 0=always
  // ready, 1=random, 2=three-cycle stall mid-line. abort_at>0 resets after that pixel.
  task automatic apply_stimulus(input logic [1:0] k, input int vmode, input int rmode,
                                input bit mid_start, input int abort_at);
    int p, cyc;
    logic acc;
    for (int i = 0; i < 200 && busy; i++) begin
      @(posedge clk); #1;
    end
    check_output("idle_before_start", busy, 0);
    start = 1'b1; kernel_sel = k; exp_kernel = k;
    @(posedge clk); #1;
    start = 1'b0; kernel_sel = 2'($urandom);
    check_output("busy_after_start", busy, 1);
    p = 0; cyc = 0;
    while (p < NPIX && cyc < 2000) begin
      in_valid   = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom);
      in_data    = (vmode == 2) ? W'($urandom) : W'(p + 1);
      conv_ready = ready_for(rmode, cyc);
      if (mid_start && cyc == 3) begin
        start = 1'b1; kernel_sel = 2'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) p++;
      cyc++;
      if (abort_at > 0 && p == abort_at) break;
    end
    in_valid = 1'b0; start = 1'b0;
    if (abort_at > 0) begin
      rst_n = 1'b0;
      #1;
      check_output("rst_conv_valid", conv_valid, 0);
      check_output("rst_conv_data", conv_data, 0);
      check_output("rst_border", border, 0);
      check_output("rst_conv_kernel", conv_kernel, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_done", done, 0);
      check_output("rst_in_ready", in_ready, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      return;
    end
    check_output("pixels_accepted", p, NPIX);
    cyc = 0;
    while (busy && cyc < 500) begin
      conv_ready = ready_for(rmode == 2 ? 0 : rmode, cyc);
      @(posedge clk); #1;
      cyc++;
    end
    check_output("frame_finished", busy, 0);
    @(negedge clk);
    check_output("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; kernel_sel = 2'b00;
    in_data = '0; in_valid = 1'b0; conv_ready = 1'b1;
    #2;
    check_output("reset_busy", busy, 0);
    check_output("reset_valid", conv_valid, 0);
    check_output("reset_kernel", conv_kernel, 0);
    check_output("reset_in_ready", in_ready, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    apply_stimulus(2'd2, 0, 0, 1'b0, 0);
    apply_stimulus(2'd2, 0, 2, 1'b0, 0);
    apply_stimulus(2'd2, 0, 0, 1'b1, 0);
    apply_stimulus(2'd3, 0, 0, 1'b0, 7);
    apply_stimulus(2'd1, 0, 0, 1'b0, 0);
    apply_stimulus(2'd0, 1, 0, 1'b0, 0);
    for (int n = 0; n < 10; n++)
      apply_stimulus(2'($urandom), 2, 1, ($urandom_range(0, 1) == 1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_frame_ctrl.md
CONV_FRAME_CTRL -- requirements
Module: conv_frame_ctrl

Interface
REQ-001 SHALL have parameter W, default 30: pixel data width, matching the convolution datapath stream width.
REQ-002 SHALL have parameter IMG_W, default 320: pixels per line.
REQ-003 SHALL have parameter IMG_H, default 240: lines per frame.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: single-cycle frame start request.
REQ-007 SHALL have port kernel_sel, input, 2: kernel select, sampled only when start is accepted.
REQ-008 SHALL have port in_data, input, W: camera pixel.
REQ-009 SHALL have port in_valid, input, 1: in_data is valid.
REQ-010 SHALL have port in_ready, output, 1: controller accepts the pixel.
REQ-011 SHALL have port conv_data, output, W: pixel sent to the convolution datapath.
REQ-012 SHALL have port conv_valid, output, 1: conv_data is valid.
REQ-013 SHALL have port conv_ready, input, 1: the datapath accepts the pixel.
REQ-014 SHALL have port conv_kernel, output, 2: latched kernel select, held for the whole frame.
REQ-015 SHALL have port border, output, 1: the current conv_data lies on the frame edge or is a flush pixel.
REQ-016 SHALL have port busy, output, 1: the FSM is not IDLE.
REQ-017 SHALL have port done, output, 1: single-cycle end-of-frame pulse.

Function
REQ-018 SHALL implement an FSM with states IDLE, RUN, FLUSH and DONE.
REQ-019 SHALL move IDLE->RUN on start=1, latch kernel_sel into conv_kernel, and clear col and row to 0.
REQ-020 SHALL ignore start in any state other than IDLE, with no effect on counters or conv_kernel.
REQ-021 SHALL hold a single-entry output register (conv_data, conv_valid, border); transfer occurs when conv_valid&&conv_ready.
REQ-022 SHALL drive in_ready = (state==RUN) && (!conv_valid || conv_ready), combinationally.
REQ-023 SHALL keep in_ready=0 in IDLE, FLUSH and DONE; the camera stalls outside RUN.
REQ-024 SHALL, on an input accept (in_valid&&in_ready), load the output register the next cycle with conv_data=in_data and conv_valid=1, giving 1-cycle latency.
REQ-025 SHALL hold conv_data, border and conv_valid stable while conv_valid=1 and conv_ready=0.
REQ-026 SHALL set border=1 when col==0, col==IMG_W-1, row==0 or row==IMG_H-1 for the accepted pixel.
REQ-027 SHALL, on each accept, increment col; at col==IMG_W-1 it wraps col to 0 and increments row.
REQ-028 SHALL, on accepting pixel (IMG_W-1, IMG_H-1), go RUN->FLUSH and load the flush counter with IMG_W+1.
REQ-029 SHALL, in FLUSH, inject zero pixels (conv_data=0, border=1) through the same output register under the same handshake.
REQ-030 SHALL decrement the flush counter per injected pixel loaded; it goes FLUSH->DONE when the last flush pixel has been transferred and the register is empty.
REQ-031 SHALL assert done=1 for exactly the one DONE cycle, then go DONE->IDLE.
REQ-032 SHALL keep conv_kernel constant from start acceptance until the next accepted start.
REQ-033 SHALL keep busy=1 in RUN, FLUSH and DONE.
REQ-034 SHALL size col and row counters to clog2(IMG_W) and clog2(IMG_H) bits; no other wrap is permitted.

Reset
REQ-035 SHALL, on rst_n=0 at any time, asynchronously force state=IDLE, col=row=0, flush counter=0, conv_valid=0, conv_data=0, border=0, conv_kernel=0, busy=0, done=0 and in_ready=0.
REQ-036 SHALL treat a reset mid-frame as abandoning the frame: no done pulse is issued, and the next frame requires a new start.

Verification (use IMG_W=4, IMG_H=3, W=30)
REQ-037 SHALL be checked for: start with kernel_sel=2, then 12 pixels 1..12 with conv_ready=1 throughout -> conv_data 1..12 each 1 cycle after accept, then 5 zeros, border pattern 1111,1001,1111,11111, and done 1 cycle after the last flush transfer; conv_kernel=2 throughout.
REQ-038 SHALL be checked for: conv_ready held 0 for 3 cycles mid-line -> in_ready=0, conv_data and border stable, no pixel lost or duplicated.
REQ-039 SHALL be checked for: start pulsed in RUN with kernel_sel=1 -> conv_kernel remains 2 and counters are unaffected.
REQ-040 SHALL be checked for: rst_n low after pixel 7 -> all outputs 0 immediately, no done, and the following start plus 12 pixels completes normally.
REQ-041 SHALL be checked for: in_valid toggling every other cycle -> col/row advance only on accepts, and the flush begins only after pixel 12.
